tinyalu_param: RTL and testbench
================================

Name: tinyalu_param

Overview:
- Parametrised next-generation TinyALU DUT.
- Operand width is configurable. Adds a subtract op, an error flag on illegal opcodes, and a busy output.
- Uses an iterative shift-add multiplier so the multi-cycle op has a width-dependent latency.
- Sits as the DUT under the class-based bench (tpgen / scoreboard / coverage) and reuses the shared operation encoding.

Parameters:
- WIDTH, 8, operand width in bits; result is 2*WIDTH bits; legal range 2..32.

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  synchronous, active-low reset; sampled on the rising edge of clk.
- A  in  WIDTH  operand A (unsigned).
- B  in  WIDTH  operand B (unsigned).
- op  in  3  operation_t opcode.
- start  in  1  request; sampled only when busy=0.
- busy  out  1  high from the cycle after acceptance until the cycle done is high (inclusive).
- done  out  1  one-cycle completion pulse.
- err  out  1  valid only with done; 1 = illegal opcode.
- result  out  2*WIDTH  result; holds its value between completions.

Behaviour:
- Reset (reset_n=0 at a clk edge): state=IDLE, busy=0, done=0, err=0, result=0. Reset overrides everything, including an in-flight multiply, which is aborted with no done.
- Acceptance: in IDLE, at the clk edge where start=1, A, B and op are latched (call this cycle 0). Inputs after cycle 0 are ignored until the next IDLE.
- no_op (000): accepted but no effect; no done, no busy; result held.
- rst_op (111): result cleared to 0 at cycle 1; no done; busy stays 0.
- add_op (001): result = zero-extended A+B. Carry lands in bit WIDTH.
- and_op (010): result = zero-extended A & B.
- xor_op (011): result = zero-extended A ^ B.
- sub_op (101): result = (zero-ext A) - (zero-ext B) modulo 2^(2*WIDTH). If A<B the upper bits are all 1.
- For add/and/xor/sub: state IDLE->DONE. done=1, err=0 and the new result appear in cycle 1; the machine returns to IDLE in cycle 2.
- inv_op (110): done=1, err=1, result=0 in cycle 1.
- mul_op (100): state IDLE->MUL.
  - WIDTH iterations, one multiplier bit per cycle, LSB first; accumulator is 2*WIDTH bits.
  - MUL->DONE after the WIDTH-th iteration.
  - done=1, err=0, result=A*B in cycle WIDTH+1.
- State machine: IDLE -> (ALU1 ops) DONE; IDLE -> (mul) MUL -> DONE; DONE -> IDLE unconditionally.
- Back-to-back: start is not sampled in DONE. Earliest next acceptance is the cycle after done, so the single-cycle throughput is one op per 2 cycles.
- start held high continuously: one op executes per acceptance window. No queueing.
- start=1 with busy=1: ignored, with no side effect.
- done is never asserted in two consecutive cycles. err=0 whenever done=0.

Decomposition:
- Shared package tinyalu_pkg:
  - operation_t extends to no_op 000, add_op 001, and_op 010, xor_op 011, mul_op 100, sub_op 101, inv_op 110, rst_op 111.
  - Adds a state enum alu_state_t {IDLE, MUL, DONE}.
- Sub-module tinyalu_mul_iter:
  - Inputs: clk, reset_n, load, A, B.
  - Outputs: product, ready.
  - WIDTH-cycle shift-add. The top level owns the handshake and result register.

Test Plan (WIDTH=8):
- Reset then add: A=0xFF, B=0x01, op=add, start for 1 cycle -> done in cycle 1, result=0x0100, err=0; busy=1 in cycle 1 only.
- Multiply extreme: A=0xFF, B=0xFF, op=mul -> busy cycles 1..9, done only in cycle 9, result=0xFE01. Also A=0, B=0xAB -> result=0x0000 in cycle 9.
- Subtract wrap: A=0x03, B=0x05, op=sub -> result=0xFFFE in cycle 1. Then A=0x05, B=0x03 -> result=0x0002.
- Illegal op and rst_op: op=110 -> done=1, err=1, result=0x0000 in cycle 1. Then result=0x1234 (from a prior mul 0x34*... or any) followed by op=rst -> result=0 with done never pulsed.
- Busy/ignore: start a mul with A=0x10, B=0x10, then in cycle 3 drive start with op=add, A=1, B=1 -> ignored; result=0x0100 in cycle 9 with exactly one done.
- Reset mid-operation: start mul, drive reset_n=0 at cycle 4 -> busy=0, result=0, no done. An add started after reset completes normally.

Source files
------------

// File: rtl/tinyalu_pkg.sv
// Shared TinyALU encodings: opcode set and controller states.
package tinyalu_pkg;

   typedef enum logic [2:0] {
      no_op  = 3'b000,
      add_op = 3'b001,
      and_op = 3'b010,
      xor_op = 3'b011,
      mul_op = 3'b100,
      sub_op = 3'b101,
      inv_op = 3'b110,
      rst_op = 3'b111
   } operation_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MUL  = 2'd1,
      DONE = 2'd2
   } alu_state_t;

endpackage

// File: rtl/tinyalu_mul_iter.sv
// Iterative shift-add multiplier: one multiplier bit per cycle, LSB first, WIDTH cycles.
module tinyalu_mul_iter
#(
   parameter int WIDTH = 8
)(
   input  logic               clk,
   input  logic               reset_n,
   input  logic               load,
   input  logic [WIDTH-1:0]   A,
   input  logic [WIDTH-1:0]   B,
   output logic [2*WIDTH-1:0] product,
   output logic               ready
);

   localparam int CW = $clog2(WIDTH + 1);

   logic [2*WIDTH-1:0] mcand_reg;
   logic [WIDTH-1:0]   mplier_reg;
   logic [2*WIDTH-1:0] acc_reg;
   logic [CW-1:0]      count_reg;
   logic [2*WIDTH-1:0] acc_next;

   // product/ready describe the iteration taking place at the coming edge, so the
   // controller can capture the final product on the same edge as the last step.
   always_comb begin
      acc_next = acc_reg + (mplier_reg[0] ? mcand_reg : '0);
      product  = acc_next;
      ready    = (count_reg == CW'(1));
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         mcand_reg  <= '0;
         mplier_reg <= '0;
         acc_reg    <= '0;
         count_reg  <= '0;
      end else if (load) begin
         mcand_reg  <= {{WIDTH{1'b0}}, A};
         mplier_reg <= B;
         acc_reg    <= '0;
         count_reg  <= CW'(WIDTH);
      end else if (count_reg != '0) begin
         acc_reg    <= acc_next;
         mcand_reg  <= mcand_reg << 1;
         mplier_reg <= mplier_reg >> 1;
         count_reg  <= count_reg - CW'(1);
      end
   end

endmodule

// File: rtl/tinyalu_param.sv
// Parametrised TinyALU: single-cycle add/and/xor/sub, iterative multiply, illegal-op flag.
module tinyalu_param
   import tinyalu_pkg::*;
#(
   parameter int WIDTH = 8
)(
   input  logic               clk,
   input  logic               reset_n,
   input  logic [WIDTH-1:0]   A,
   input  logic [WIDTH-1:0]   B,
   input  logic [2:0]         op,
   input  logic               start,
   output logic               busy,
   output logic               done,
   output logic               err,
   output logic [2*WIDTH-1:0] result
);

   alu_state_t         state_reg, state_next;
   logic [2*WIDTH-1:0] result_reg, result_next;
   logic               err_reg, err_next;
   logic               mul_load;
   logic [2*WIDTH-1:0] mul_product;
   logic               mul_ready;
   logic [2*WIDTH-1:0] a_ext, b_ext;
   operation_t         op_e;

   assign a_ext = {{WIDTH{1'b0}}, A};
   assign b_ext = {{WIDTH{1'b0}}, B};
   assign op_e  = operation_t'(op);

   tinyalu_mul_iter #(.WIDTH(WIDTH)) u_mul (
      .clk     (clk),
      .reset_n (reset_n),
      .load    (mul_load),
      .A       (A),
      .B       (B),
      .product (mul_product),
      .ready   (mul_ready)
   );

   always_comb begin
      state_next  = state_reg;
      result_next = result_reg;
      err_next    = err_reg;
      mul_load    = 1'b0;
      unique case (state_reg)
         IDLE: begin
            if (start) begin
               unique case (op_e)
                  add_op: begin result_next = a_ext + b_ext; err_next = 1'b0; state_next = DONE; end
                  and_op: begin result_next = a_ext & b_ext; err_next = 1'b0; state_next = DONE; end
                  xor_op: begin result_next = a_ext ^ b_ext; err_next = 1'b0; state_next = DONE; end
                  sub_op: begin result_next = a_ext - b_ext; err_next = 1'b0; state_next = DONE; end
                  inv_op: begin result_next = '0;            err_next = 1'b1; state_next = DONE; end
                  mul_op: begin mul_load = 1'b1;             err_next = 1'b0; state_next = MUL;  end
                  rst_op: result_next = '0;
                  default: ;
               endcase
            end
         end
         MUL: begin
            if (mul_ready) begin
               result_next = mul_product;
               state_next  = DONE;
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_reg  <= IDLE;
         result_reg <= '0;
         err_reg    <= 1'b0;
      end else begin
         state_reg  <= state_next;
         result_reg <= result_next;
         err_reg    <= err_next;
      end
   end

   // err is qualified by done so it reads 0 outside the completion pulse.
   assign busy   = (state_reg != IDLE);
   assign done   = (state_reg == DONE);
   assign err    = done & err_reg;
   assign result = result_reg;

endmodule

// File: tb/tb_tinyalu_param.sv
// Directed table-driven bench for tinyalu_param at WIDTH=8.
module tb_tinyalu_param;

   logic        clk = 1'b0;
   logic        reset_n;
   logic [7:0]  a_s, b_s;
   logic [2:0]  op_s;
   logic        start;
   logic        busy, done, err;
   logic [15:0] result;

   int checks = 0;
   int errors = 0;

   tinyalu_param #(.WIDTH(8)) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .A       (a_s),
      .B       (b_s),
      .op      (op_s),
      .start   (start),
      .busy    (busy),
      .done    (done),
      .err     (err),
      .result  (result)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  op;
      logic [7:0]  a;
      logic [7:0]  b;
      logic [15:0] exp_result;
      logic        exp_err;
      int          lat;        // cycle of done after acceptance, 0 = no done expected
      string       name;
   } vec_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Drive one request for a single edge, then check busy/done/err every cycle up to
   // one cycle past the expected completion.
   task automatic do_op(input vec_t v);
      op_s = v.op; a_s = v.a; b_s = v.b; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 1; k <= v.lat + 1; k++) begin
         chk({v.name, " done"}, 32'(done), 32'(k == v.lat));
         chk({v.name, " busy"}, 32'(busy), 32'(v.lat > 0 && k <= v.lat));
         chk({v.name, " err"},  32'(err),  32'((k == v.lat) ? v.exp_err : 1'b0));
         if (k == v.lat || v.lat == 0)
            chk({v.name, " result"}, 32'(result), 32'(v.exp_result));
         if (k <= v.lat) begin
            @(posedge clk); #1;
         end
      end
      $display("op=%0d A=%02h B=%02h result=%04h err=%0b (%s)", v.op, v.a, v.b, result, err, v.name);
   endtask

   vec_t vecs[$];

   initial begin
      int dcount;

      vecs = '{
         '{3'b001, 8'hFF, 8'h01, 16'h0100, 1'b0, 1, "add_carry"},
         '{3'b100, 8'hFF, 8'hFF, 16'hFE01, 1'b0, 9, "mul_ff_ff"},
         '{3'b100, 8'h00, 8'hAB, 16'h0000, 1'b0, 9, "mul_zero"},
         '{3'b101, 8'h03, 8'h05, 16'hFFFE, 1'b0, 1, "sub_wrap"},
         '{3'b101, 8'h05, 8'h03, 16'h0002, 1'b0, 1, "sub_pos"},
         '{3'b110, 8'h12, 8'h34, 16'h0000, 1'b1, 1, "inv_op"},
         '{3'b010, 8'hF0, 8'h3C, 16'h0030, 1'b0, 1, "and"},
         '{3'b011, 8'hF0, 8'h3C, 16'h00CC, 1'b0, 1, "xor"},
         '{3'b000, 8'h77, 8'h11, 16'h00CC, 1'b0, 0, "no_op_hold"},
         '{3'b100, 8'h0D, 8'h0B, 16'h008F, 1'b0, 9, "mul_0d_0b"},
         '{3'b001, 8'h80, 8'h80, 16'h0100, 1'b0, 1, "add_80_80"},
         '{3'b100, 8'h34, 8'h5A, 16'h1248, 1'b0, 9, "mul_34_5a"},
         '{3'b111, 8'h00, 8'h00, 16'h0000, 1'b0, 0, "rst_op"},
         '{3'b100, 8'h10, 8'h10, 16'h0100, 1'b0, 9, "mul_10_10"}
      };

      reset_n = 1'b0; start = 1'b0; op_s = 3'b000; a_s = '0; b_s = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset busy",   32'(busy),   32'd0);
      chk("reset done",   32'(done),   32'd0);
      chk("reset err",    32'(err),    32'd0);
      chk("reset result", 32'(result), 32'd0);
      reset_n = 1'b1;
      @(posedge clk); #1;

      foreach (vecs[i]) do_op(vecs[i]);

      // start raised mid-multiply must be ignored
      op_s = 3'b100; a_s = 8'h10; b_s = 8'h10; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      dcount = 0;
      for (int k = 1; k <= 10; k++) begin
         if (done) dcount++;
         if (k == 9) begin
            chk("ignore done@9",   32'(done),   32'd1);
            chk("ignore result@9", 32'(result), 32'h0100);
         end
         if (k == 3) begin op_s = 3'b001; a_s = 8'h01; b_s = 8'h01; start = 1'b1; end
         if (k == 4) start = 1'b0;
         @(posedge clk); #1;
      end
      chk("ignore done count", 32'(dcount), 32'd1);
      chk("ignore result end", 32'(result), 32'h0100);
      $display("busy-ignore: mul 10*10 with add during busy, result=%04h dones=%0d", result, dcount);

      // reset aborts an in-flight multiply
      op_s = 3'b100; a_s = 8'hFF; b_s = 8'hFF; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      reset_n = 1'b0;
      @(posedge clk); #1;
      reset_n = 1'b1;
      chk("midreset busy",   32'(busy),   32'd0);
      chk("midreset done",   32'(done),   32'd0);
      chk("midreset result", 32'(result), 32'd0);
      dcount = 0;
      for (int k = 0; k < 12; k++) begin
         @(posedge clk); #1;
         if (done) dcount++;
      end
      chk("midreset no done", 32'(dcount), 32'd0);
      $display("mid-reset: mul aborted, result=%04h dones=%0d", result, dcount);
      do_op('{3'b001, 8'h02, 8'h03, 16'h0005, 1'b0, 1, "add_after_reset"});

      // start held high: one acceptance per 2 cycles, done never back to back
      op_s = 3'b001; a_s = 8'h01; b_s = 8'h02; start = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         @(posedge clk); #1;
         chk($sformatf("held done c%0d", k), 32'(done), 32'(k % 2));
      end
      start = 1'b0;
      chk("held result", 32'(result), 32'h0003);
      $display("start-held: add 01+02 result=%04h", result);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
